multiplier_timing: RTL and testbench

Multi-cycle multiplier/accumulator that rebuilds a dividend from divider results by computing Product = Ain × Bin + Cin, where Ain is the divisor, Bin the quotient and Cin the remainder. It is the inverse of our divider. It uses the same one-hot INITIAL/COMPUTE/DONE_S control unit, the same Start/Ack/Done handshake and the same SCEN single-step gating, so both blocks can share one Nexys 4 top-level and one push-button stepping scheme. The block also flags whether Cin is a legal remainder for Ain.

---
 rtl/multiplier_timing_if.sv | 28 ++
 rtl/multiplier_timing.sv | 114 +++++++++++
 tb/tb_multiplier_timing.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/multiplier_timing_if.sv
// Operand, handshake and result bundle for multiplier_timing.
// master drives the operands and handshake; slave is the multiplier itself.
interface multiplier_timing_if #(
  parameter int unsigned N = 8
) ();
  logic [N-1:0]   Ain;
  logic [N-1:0]   Bin;
  logic [N-1:0]   Cin;
  logic           Start;
  logic           Ack;
  logic           SCEN;
  logic [2*N-1:0] Product;
  logic           RemOk;
  logic           Done;
  logic           Qi;
  logic           Qc;
  logic           Qd;

  modport master (
    output Ain, Bin, Cin, Start, Ack, SCEN,
    input  Product, RemOk, Done, Qi, Qc, Qd
  );

  modport slave (
    input  Ain, Bin, Cin, Start, Ack, SCEN,
    output Product, RemOk, Done, Qi, Qc, Qd
  );
endinterface

// File: rtl/multiplier_timing.sv
// Multi-cycle Product = Ain*Bin + Cin with one-hot INITIAL/COMPUTE/DONE_S control and SCEN stepping.
// Define MULT_SHIFT_ADD_EN for fixed-latency shift-and-add; default is repeated addition.
module multiplier_timing #(
  parameter int unsigned N = 8
) (
  input logic               Clk,
  input logic               Reset,
  multiplier_timing_if.slave bus
);

  typedef enum logic [2:0] {
    StInitial = 3'b001,
    StCompute = 3'b010,
    StDone    = 3'b100
  } state_t;

  state_t         state_q, state_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [2*N-1:0] a_q, a_d;
  logic           remok_q, remok_d;

`ifdef MULT_SHIFT_ADD_EN
  localparam int unsigned IW = $clog2(N + 1);
  logic [N-1:0]  m_q, m_d;
  logic [IW-1:0] i_q, i_d;
`else
  logic [N-1:0]  cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_d     = a_q;
    remok_d = remok_q;
`ifdef MULT_SHIFT_ADD_EN
    m_d     = m_q;
    i_d     = i_q;
`else
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      StInitial: begin
        // Operands are reloaded every cycle so the Start edge captures them.
        acc_d   = {{N{1'b0}}, bus.Cin};
        a_d     = {{N{1'b0}}, bus.Ain};
        remok_d = (bus.Cin < bus.Ain);
`ifdef MULT_SHIFT_ADD_EN
        m_d     = bus.Bin;
        i_d     = '0;
`else
        cnt_d   = bus.Bin;
`endif
        if (bus.Start) state_d = StCompute;
      end
      StCompute: begin
        if (bus.SCEN) begin
`ifdef MULT_SHIFT_ADD_EN
          if (i_q == IW'(N)) begin
            state_d = StDone;
          end else begin
            if (m_q[0]) acc_d = acc_q + a_q;
            a_d = a_q << 1;
            m_d = m_q >> 1;
            i_d = i_q + IW'(1);
          end
`else
          if (cnt_q == '0) begin
            state_d = StDone;
          end else begin
            acc_d = acc_q + a_q;
            cnt_d = cnt_q - N'(1);
          end
`endif
        end
      end
      StDone: begin
        if (bus.Ack) state_d = StInitial;
      end
      default: state_d = StInitial;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StInitial;
      acc_q   <= '0;
      a_q     <= '0;
      remok_q <= 1'b0;
`ifdef MULT_SHIFT_ADD_EN
      m_q     <= '0;
      i_q     <= '0;
`else
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      remok_q <= remok_d;
`ifdef MULT_SHIFT_ADD_EN
      m_q     <= m_d;
      i_q     <= i_d;
`else
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign {bus.Qd, bus.Qc, bus.Qi} = state_q;
  assign bus.Done    = state_q[2];
  assign bus.Product = acc_q;
  assign bus.RemOk   = remok_q;

endmodule

// File: tb/tb_multiplier_timing.sv
// Directed bench for multiplier_timing: nominal, boundary, SCEN stepping, reset and handshake.
module tb_multiplier_timing;

  localparam int unsigned N = 8;
`ifdef MULT_SHIFT_ADD_EN
  localparam bit ShiftAdd = 1'b1;
`else
  localparam bit ShiftAdd = 1'b0;
`endif

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  multiplier_timing_if #(.N(N)) bus ();

  multiplier_timing #(.N(N)) dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lat(input int bin);
    return ShiftAdd ? int'(N) + 1 : bin + 1;
  endfunction

  // Waits for Done (bounded) and returns the number of COMPUTE clocks taken.
  task automatic wait_done(output int n);
    n = 0;
    while (bus.Done !== 1'b1 && n < 600) begin
      tick();
      n++;
    end
  endtask

  task automatic run_op(input string tag, input int ain, input int bin, input int cin,
                        input int exp_prod, input bit exp_rem);
    int n;
    bus.Ain = ain[N-1:0];
    bus.Bin = bin[N-1:0];
    bus.Cin = cin[N-1:0];
    bus.SCEN  = 1'b1;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    check({tag, "_qc"}, {31'd0, bus.Qc}, 32'd1);
    wait_done(n);
    check({tag, "_lat"}, n, lat(bin));
    check({tag, "_prod"}, {16'd0, bus.Product}, exp_prod);
    check({tag, "_remok"}, {31'd0, bus.RemOk}, {31'd0, exp_rem});
    check({tag, "_state"}, {29'd0, bus.Qd, bus.Qc, bus.Qi}, 32'd4);
  endtask

  task automatic ack_back();
    bus.Ack = 1'b1;
    tick();
    bus.Ack = 1'b0;
    check("ack_qi", {31'd0, bus.Qi}, 32'd1);
  endtask

  initial begin
    int exp_step [9];
    int pulses;
    int n;

    reset = 1'b1;
    bus.Ain = '0; bus.Bin = '0; bus.Cin = '0;
    bus.Start = 1'b0; bus.Ack = 1'b0; bus.SCEN = 1'b0;
    tick();
    tick();
    check("rst_state", {29'd0, bus.Qd, bus.Qc, bus.Qi}, 32'd1);
    check("rst_done", {31'd0, bus.Done}, 32'd0);
    check("rst_prod", {16'd0, bus.Product}, 32'd0);
    check("rst_remok", {31'd0, bus.RemOk}, 32'd0);
    reset = 1'b0;
    tick();

    // Nominal, then hold in DONE_S with Start asserted and Ack low.
    run_op("nominal", 17, 13, 5, 226, 1'b1);
    bus.Start = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("hold", {15'd0, bus.Done, bus.Product}, {15'd0, 1'b1, 16'd226});
    end
    bus.Start = 1'b0;
    bus.Ack   = 1'b1;
    tick();
    bus.Ack   = 1'b0;
    check("hs_qi", {31'd0, bus.Qi}, 32'd1);
    check("hs_prod_hold", {16'd0, bus.Product}, 32'd226);
    tick();
    check("hs_reload", {16'd0, bus.Product}, 32'd5);

    // Start and Ack together in INITIAL: Start wins.
    bus.Ack = 1'b1;
    run_op("zero_mult", 9, 0, 4, 4, 1'b1);
    bus.Ack = 1'b0;
    ack_back();

    run_op("max", 255, 255, 254, 65279, 1'b1);
    ack_back();

    // Illegal remainder with one SCEN pulse in every five clocks.
    if (ShiftAdd) begin
      exp_step = '{16, 30, 30, 30, 30, 30, 30, 30, 30};
      pulses = 9;
    end else begin
      exp_step = '{16, 23, 30, 30, 0, 0, 0, 0, 0};
      pulses = 4;
    end
    bus.Ain = 8'd7; bus.Bin = 8'd3; bus.Cin = 8'd9;
    bus.SCEN = 1'b0;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    check("step_start", {16'd0, bus.Product}, 32'd9);
    for (int p = 0; p < pulses; p++) begin
      bus.SCEN = 1'b1;
      tick();
      bus.SCEN = 1'b0;
      check("step_prod", {16'd0, bus.Product}, exp_step[p]);
      check("step_done", {31'd0, bus.Done}, (p == pulses - 1) ? 32'd1 : 32'd0);
      if (p != pulses - 1) begin
        for (int k = 0; k < 4; k++) tick();
        check("step_stall", {15'd0, bus.Qc, bus.Product}, {15'd0, 1'b1, exp_step[p][15:0]});
      end
    end
    check("step_remok", {31'd0, bus.RemOk}, 32'd0);
    ack_back();

    // Reset asserted mid-COMPUTE while Product=16.
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    bus.SCEN = 1'b1;
    tick();
    bus.SCEN = 1'b0;
    check("mid_prod", {16'd0, bus.Product}, 32'd16);
    reset = 1'b1;
    #1;
    check("arst_qi", {29'd0, bus.Qd, bus.Qc, bus.Qi}, 32'd1);
    check("arst_prod", {16'd0, bus.Product}, 32'd0);
    check("arst_done", {31'd0, bus.Done}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    run_op("post_rst", 3, 2, 1, 7, 1'b1);
    wait_done(n);
    ack_back();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
